// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   INSTR_W / ADDR_W  : instruction word and byte-address widths
//   PC_STEP           : PC increment per fetched word (bytes)
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   fetch_entry_t     : one instruction queue entry {instr, pc}
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction queue for the fetch stage.
//   clk_i        : clock, all state on posedge
//   reset_i      : synchronous active-high reset (empties the queue)
//   flush_i      : synchronous flush (empties the queue, wins over push/pop)
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : entry at the head (undefined contents when count_o == 0)
//   count_o      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_eff;

    // A pop against an empty queue is a no-op.
    assign pop_eff = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_eff) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_eff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The issue logic upstream must never let a push land on a full queue.
            assert (flush_i || !(push_i && !pop_eff && count_q == CW'(DEPTH)));
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, reads a registered
// byte-addressed ROM, queues {word, pc} and hands them to decode.
//   clk            : clock, all state on posedge
//   reset          : synchronous active-high reset
//   rom_enable     : ROM read strobe (ROM samples rom_address at posedge)
//   rom_address    : byte address being fetched (= PC)
//   rom_data       : ROM word, valid the cycle after rom_enable
//   redirect_valid : one-cycle pulse, flush everything and restart at redirect_pc
//   redirect_pc    : new fetch address
//   instr_valid    : queue head valid
//   instr_ready    : decode accepts the head this cycle
//   instr_out      : head instruction word (0 when !instr_valid)
//   instr_pc       : head byte address (0 when !instr_valid)
//   fetch_fault    : misaligned redirect seen (sticky until reset)
// Handshake: a transfer happens on a cycle where instr_valid && instr_ready;
// while instr_valid && !instr_ready the head holds still, and instr_valid
// only drops after a transfer, a redirect or a reset.
// Optional build macro FETCH_ALIGN_CHECK_EN: when defined, a redirect with
// redirect_pc[1:0] != 0 raises fetch_fault and halts fetch until reset; when
// undefined, the low two redirect bits are forced to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               rom_enable,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              halted;
    logic [ADDR_W-1:0] redirect_target;

    logic              push, pop;
    fetch_entry_t      push_entry, head;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occ_next;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redirect_target = redirect_pc;
    assign fault_d = fault_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign halted      = fault_q;
    assign fetch_fault = fault_q;
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign halted               = 1'b0;
    assign fetch_fault          = 1'b0;
`endif

    // Head is hidden during reset and during a redirect cycle.
    assign instr_valid = !reset && !redirect_valid && (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr_out   = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

    // Occupancy after this edge if nothing new issues: queued + arriving - leaving.
    // pop implies fifo_count >= 1, so this never underflows.
    assign occ_next = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign rom_enable  = !reset && !redirect_valid && !halted && (occ_next < (CW+1)'(DEPTH));
    assign rom_address = pc_q;

    // The word returning from the ROM this cycle is squashed by a redirect.
    assign push       = inflight_q && !redirect_valid;
    assign push_entry = '{instr: rom_data, pc: inflight_pc_q};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (rom_enable) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit (DEPTH = 4, RESET_PC = 0).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rom_enable     (rom_enable),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    // ---------------- ROM model: byte b(a) = xor of the address bytes ----------------
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
    endfunction

    always @(posedge clk) begin
        if (rom_enable) rom_data <= rom_word(rom_address);
    end

    function automatic logic [31:0] redirect_dest(input logic [31:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    // ---------------- Scoreboard: delivered stream = next_pc, next_pc+4, ... ----------------
    logic [31:0] exp_pc = 32'h0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_out = 32'h0;
    logic [31:0] prev_pc = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc     = 32'h0;
            prev_stall = 1'b0;
        end else begin
            if (!instr_valid) begin
                checks++;
                if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin
                    failures++;
                    $display("FAIL idle_zero: got out=%h pc=%h, expected 0/0", instr_out, instr_pc);
                end
            end
            if (prev_stall && !redirect_valid) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_out !== prev_out || instr_pc !== prev_pc) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b out=%h pc=%h, expected v=1 out=%h pc=%h",
                             instr_valid, instr_out, instr_pc, prev_out, prev_pc);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr_out !== rom_word(exp_pc)) begin
                    failures++;
                    $display("FAIL stream: got pc=%h out=%h, expected pc=%h out=%h",
                             instr_pc, instr_out, exp_pc, rom_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_dest(redirect_pc);
            prev_stall = instr_valid && !instr_ready;
            prev_out   = instr_out;
            prev_pc    = instr_pc;
        end
    end

    // ---------------- Driver ----------------
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(negedge clk);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            reset          = 1'b1;
            redirect_valid = 1'b0;
            instr_ready    = 1'b1;
            @(negedge clk);
            checks++;
            if (rom_enable !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs: got en=%b v=%b out=%h pc=%h, expected 0/0/0/0",
                         rom_enable, instr_valid, instr_out, instr_pc);
            end
            if (i == 1) begin
                checks++;
                if (fetch_fault !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_fault: got %b expected 0", fetch_fault);
                end
            end
        end
    endtask

    task automatic test_reset_fetch();
        logic [31:0] want_pc;
        test_reset();
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (rom_enable !== 1'b1 || rom_address !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_issue: got en=%b addr=%h v=%b, expected 1/00000000/0", rom_enable, rom_address, instr_valid);
        end
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || rom_address !== 32'h4) begin
            failures++;
            $display("FAIL second_cycle: got v=%b addr=%h, expected 0/00000004", instr_valid, rom_address);
        end
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h03020100 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL first_valid: got v=%b out=%h pc=%h, expected 1/03020100/00000000", instr_valid, instr_out, instr_pc);
        end
        for (int i = 1; i <= 3; i++) begin
            want_pc = 32'(i * 4);
            step(1'b0, 32'h0, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== want_pc) begin
                failures++;
                $display("FAIL steady_pc: got v=%b pc=%h, expected 1/%h", instr_valid, instr_pc, want_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic [31:0] want;
        int issues = 0;
        logic seen = 1'b0;
        test_reset();
        for (int i = 0; i < 8 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (rom_enable) issues++;
            seen = instr_valid;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_first_valid: got no valid within 8 cycles, expected valid");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (rom_enable) issues++;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== 32'h03020100) begin
                failures++;
                $display("FAIL bp_head: got v=%b pc=%h out=%h, expected 1/00000000/03020100", instr_valid, instr_pc, instr_out);
            end
        end
        checks++;
        if (issues != 4 || rom_enable !== 1'b0 || rom_address !== 32'h10) begin
            failures++;
            $display("FAIL bp_full: got issues=%0d en=%b addr=%h, expected 4/0/00000010", issues, rom_enable, rom_address);
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            step(1'b0, 32'h0, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== want || instr_out !== rom_word(want)) begin
                failures++;
                $display("FAIL bp_drain: got v=%b pc=%h out=%h, expected 1/%h/%h", instr_valid, instr_pc, instr_out, want, rom_word(want));
            end
        end
    endtask

    task automatic test_redirect_midflight();
        test_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || rom_enable !== 1'b0) begin
            failures++;
            $display("FAIL mid_R: got v=%b en=%b, expected 0/0", instr_valid, rom_enable);
        end
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || rom_enable !== 1'b1 || rom_address !== 32'h100) begin
            failures++;
            $display("FAIL mid_R1: got v=%b en=%b addr=%h, expected 0/1/00000100", instr_valid, rom_enable, rom_address);
        end
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_R2: got v=%b expected 0", instr_valid);
        end
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== rom_word(32'h100)) begin
            failures++;
            $display("FAIL mid_R3: got v=%b pc=%h out=%h, expected 1/00000100/%h", instr_valid, instr_pc, instr_out, rom_word(32'h100));
        end
        repeat (4) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect_full();
        test_reset();
        repeat (8) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h200, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || rom_enable !== 1'b0) begin
            failures++;
            $display("FAIL full_R: got v=%b en=%b, expected 0/0", instr_valid, rom_enable);
        end
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (instr_valid !== 1'b0 || rom_enable !== 1'b1 || rom_address !== 32'h200) begin
            failures++;
            $display("FAIL full_R1: got v=%b en=%b addr=%h, expected 0/1/00000200", instr_valid, rom_enable, rom_address);
        end
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            failures++;
            $display("FAIL full_R3: got v=%b pc=%h, expected 1/00000200", instr_valid, instr_pc);
        end
        repeat (3) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_pc_wrap();
        logic [31:0] want_q[$];
        logic [31:0] want;
        test_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        want_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        while (want_q.size() > 0) begin
            want = want_q.pop_front();
            step(1'b0, 32'h0, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== want) begin
                failures++;
                $display("FAIL wrap: got v=%b pc=%h, expected 1/%h", instr_valid, instr_pc, want);
            end
        end
    endtask

    task automatic test_random();
        logic        rv, rdy;
        logic [31:0] rpc;
        test_reset();
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 29) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            step(rv, rpc, rdy);
            if (rv) begin
                checks++;
                if (instr_valid !== 1'b0 || rom_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_redirect: got v=%b en=%b, expected 0/0", instr_valid, rom_enable);
                end
            end
        end
    endtask

    task automatic test_alignment();
        test_reset();
        repeat (4) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h102, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || rom_enable !== 1'b0) begin
            failures++;
            $display("FAIL align_R: got v=%b en=%b, expected 0/0", instr_valid, rom_enable);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b1);
            checks++;
            if (fetch_fault !== 1'b1 || rom_enable !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL align_halt: got fault=%b en=%b v=%b, expected 1/0/0", fetch_fault, rom_enable, instr_valid);
            end
        end
        test_reset();
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (fetch_fault !== 1'b0 || rom_enable !== 1'b1) begin
            failures++;
            $display("FAIL align_clear: got fault=%b en=%b, expected 0/1", fetch_fault, rom_enable);
        end
`else
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (fetch_fault !== 1'b0 || rom_enable !== 1'b1 || rom_address !== 32'h100) begin
            failures++;
            $display("FAIL align_R1: got fault=%b en=%b addr=%h, expected 0/1/00000100", fetch_fault, rom_enable, rom_address);
        end
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            failures++;
            $display("FAIL align_R3: got v=%b pc=%h, expected 1/00000100", instr_valid, instr_pc);
        end
`endif
        repeat (3) step(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        test_reset_fetch();
        test_backpressure();
        test_redirect_midflight();
        test_redirect_full();
        test_pc_wrap();
        test_random();
        test_alignment();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
